// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: default word width
// and the transmitter FSM state type.
package bs_pkg;

    localparam int BS_WORD_W = 16;

    typedef enum logic {
        BS_TX_IDLE  = 1'b0,
        BS_TX_SHIFT = 1'b1
    } bs_tx_state_t;

endpackage

// File: rtl/bs_shreg.sv
// Loadable right-shift register presenting its LSB as the serial output.
// Load takes priority over shift; the vacated MSB fills with zero.
module bs_shreg
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_WORD_W
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_sh <= i_d;
        end else if (i_shift) begin
            r_sh <= {1'b0, r_sh[WIDTH-1:1]};
        end
    end

    assign o_bit = r_sh[0];

endmodule

// File: rtl/bs_word_tx.sv
// Parallel-to-bit-serial operand transmitter (LSB first, firstbit/lastbit framing).
// Define BS_TX_DBUF_EN for a one-word holding register giving gapless frames.
module bs_word_tx
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             x,
    output logic             y,
    output logic             firstbit,
    output logic             lastbit,
    output logic             busy
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    bs_tx_state_t     r_state;
    bs_tx_state_t     w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic             w_shift;
    logic             w_bit_x;
    logic             w_bit_y;
    logic [WIDTH-1:0] w_ld_x;
    logic [WIDTH-1:0] w_ld_y;

`ifdef BS_TX_DBUF_EN
    logic             r_hold_valid;
    logic [WIDTH-1:0] r_hold_x;
    logic [WIDTH-1:0] r_hold_y;
    logic             w_take_hold;
    logic             w_to_hold;

    assign in_ready = !rst && !r_hold_valid;
    assign busy     = !rst && ((r_state == BS_TX_SHIFT) || r_hold_valid);
    assign w_ld_x   = w_take_hold ? r_hold_x : in_x;
    assign w_ld_y   = w_take_hold ? r_hold_y : in_y;
`else
    assign in_ready = !rst && (r_state == BS_TX_IDLE);
    assign busy     = !rst && (r_state == BS_TX_SHIFT);
    assign w_ld_x   = in_x;
    assign w_ld_y   = in_y;
`endif

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == LAST);

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
`ifdef BS_TX_DBUF_EN
        w_take_hold = 1'b0;
        w_to_hold   = 1'b0;
`endif
        case (r_state)
            BS_TX_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    w_next = BS_TX_SHIFT;
                end
            end
            BS_TX_SHIFT: begin
                if (w_last) begin
`ifdef BS_TX_DBUF_EN
                    // Held word wins; otherwise a same-edge accept reloads directly.
                    if (r_hold_valid) begin
                        w_load      = 1'b1;
                        w_take_hold = 1'b1;
                    end else if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_next = BS_TX_IDLE;
                    end
`else
                    w_next = BS_TX_IDLE;
`endif
                end else begin
                    w_shift = 1'b1;
`ifdef BS_TX_DBUF_EN
                    w_to_hold = w_accept;
`endif
                end
            end
            default: w_next = BS_TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BS_TX_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_shift) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef BS_TX_DBUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
        end else if (w_to_hold) begin
            r_hold_valid <= 1'b1;
        end else if (w_take_hold) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_to_hold) begin
            r_hold_x <= in_x;
            r_hold_y <= in_y;
        end
    end
`endif

    bs_shreg #(.WIDTH(WIDTH)) u_shreg_x (
        .clk     (clk),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (w_ld_x),
        .o_bit   (w_bit_x)
    );

    bs_shreg #(.WIDTH(WIDTH)) u_shreg_y (
        .clk     (clk),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (w_ld_y),
        .o_bit   (w_bit_y)
    );

    // Outputs decode registered state only, so IDLE always shows zeros.
    assign x        = (r_state == BS_TX_SHIFT) && w_bit_x;
    assign y        = (r_state == BS_TX_SHIFT) && w_bit_y;
    assign firstbit = (r_state == BS_TX_SHIFT) && (r_cnt == '0);
    assign lastbit  = (r_state == BS_TX_SHIFT) && w_last;

endmodule
